// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: default sizes, the
// bit-reversal helper, the write-side state type and the Q2.14 twiddles.
package fft_pkg;

  localparam int DW_DEF    = 16;
  localparam int LOG2N_DEF = 3;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // W8^k = exp(-j*2*pi*k/8) in Q2.14 (16'h4000 = 1.0)
  localparam logic signed [15:0] TW8_0_RE = 16'sh4000;
  localparam logic signed [15:0] TW8_0_IM = 16'sh0000;
  localparam logic signed [15:0] TW8_1_RE = 16'sh2D41;
  localparam logic signed [15:0] TW8_1_IM = 16'shD2BF;
  localparam logic signed [15:0] TW8_2_RE = 16'sh0000;
  localparam logic signed [15:0] TW8_2_IM = 16'shC000;
  localparam logic signed [15:0] TW8_3_RE = 16'shD2BF;
  localparam logic signed [15:0] TW8_3_IM = 16'shD2BF;

  function automatic int unsigned bitrev(input int unsigned index, input int unsigned log2n);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < log2n; b++) begin
      r = (r << 1) | ((index >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry complex register file. Pair writes scatter a slot's two samples
// to their bit-reversed bins; two combinational ports read bins 2m and 2m+1.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [LOG2N-2:0]  wr_slot_i,
  input  logic [2*DW-1:0]   wr_lo_i,
  input  logic [2*DW-1:0]   wr_hi_i,
  input  logic [LOG2N-2:0]  rd_pair_i,
  output logic [2*DW-1:0]   rd_lo_o,
  output logic [2*DW-1:0]   rd_hi_o
);

  localparam int N  = 1 << LOG2N;
  localparam int PW = LOG2N - 1;

  logic [2*DW-1:0] entry_w [N];

  // bitrev is an involution, so bin gi is fed by slot bitrev(gi)>>1, lane bitrev(gi)&1
  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    localparam int unsigned    SRC      = bitrev(gi, LOG2N);
    localparam logic [PW-1:0]  SRC_SLOT = PW'(SRC >> 1);
    localparam bit             SRC_HI   = ((SRC & 32'd1) != 0);

    logic [2*DW-1:0] entry_q;

    always_ff @(posedge clk) begin
      if (we_i && (wr_slot_i == SRC_SLOT)) begin
        entry_q <= SRC_HI ? wr_hi_i : wr_lo_i;
      end
    end

    assign entry_w[gi] = entry_q;
  end

  assign rd_lo_o = entry_w[{rd_pair_i, 1'b0}];
  assign rd_hi_o = entry_w[{rd_pair_i, 1'b1}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder stage behind the 8-point FFT: takes bit-reversed result
// pairs, emits natural-order bin pairs with valid/ready and frame markers.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic signed [DW-1:0] in_i_real,
  input  logic signed [DW-1:0] in_i_imag,
  input  logic signed [DW-1:0] in_j_real,
  input  logic signed [DW-1:0] in_j_imag,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic signed [DW-1:0] out_i_real,
  output logic signed [DW-1:0] out_i_imag,
  output logic signed [DW-1:0] out_j_real,
  output logic signed [DW-1:0] out_j_imag,
  output logic                 overflow,
  output logic                 sync_err
);

  localparam int            N    = 1 << LOG2N;
  localparam int            NP   = N / 2;
  localparam int            PW   = LOG2N - 1;
  localparam logic [PW-1:0] LAST = PW'(NP - 1);

  wr_state_e       state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [PW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;
  logic [2*DW-1:0] out_lo_q, out_lo_d;
  logic [2*DW-1:0] out_hi_q, out_hi_d;
  logic            ovf_q, ovf_d;
  logic            sync_q, sync_d;

  logic                 we;
  logic                 set_full;
  logic [PW-1:0]        wr_slot;
  logic [1:0]           bank_we;
  logic [2*DW-1:0]      wr_lo, wr_hi;
  logic [1:0][2*DW-1:0] rd_lo_w, rd_hi_w;
  logic                 rd_load, rd_last, wr_free;
  logic [1:0]           free_clr;

  assign wr_lo   = {in_i_real, in_i_imag};
  assign wr_hi   = {in_j_real, in_j_imag};
  assign bank_we = we ? (2'b01 << wr_bank_q) : 2'b00;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    fft_reorder_bank #(
      .DW    (DW),
      .LOG2N (LOG2N)
    ) u_bank (
      .clk       (clk),
      .we_i      (bank_we[gi]),
      .wr_slot_i (wr_slot),
      .wr_lo_i   (wr_lo),
      .wr_hi_i   (wr_hi),
      .rd_pair_i (rd_cnt_q),
      .rd_lo_o   (rd_lo_w[gi]),
      .rd_hi_o   (rd_hi_w[gi])
    );
  end

  assign rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);
  assign rd_last  = rd_load && (rd_cnt_q == LAST);
  assign free_clr = rd_last ? (2'b01 << rd_bank_q) : 2'b00;
  // a bank drained on this very edge is reusable by a sop arriving now
  assign wr_free  = !full_q[wr_bank_q] || free_clr[wr_bank_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    we        = 1'b0;
    set_full  = 1'b0;
    wr_slot   = cnt_q;
    ovf_d     = ovf_q;
    sync_d    = sync_q;
    case (state_q)
      WR_IDLE: begin
        if (in_valid && in_sop) begin
          cnt_d = PW'(1);
          if (wr_free) begin
            we      = 1'b1;
            wr_slot = '0;
            state_d = WR_FILL;
          end else begin
            ovf_d   = 1'b1;
            state_d = WR_DROP;
          end
        end
      end
      WR_FILL: begin
        if (in_valid) begin
          we = 1'b1;
          if (in_sop) begin
            sync_d  = 1'b1;
            wr_slot = '0;
            cnt_d   = PW'(1);
          end else if (cnt_q == LAST) begin
            set_full  = 1'b1;
            wr_bank_d = ~wr_bank_q;
            cnt_d     = '0;
            state_d   = WR_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_DROP: begin
        if (in_valid) begin
          if (in_sop) begin
            sync_d = 1'b1;
            cnt_d  = PW'(1);
            if (wr_free) begin
              we      = 1'b1;
              wr_slot = '0;
              state_d = WR_FILL;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = WR_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = WR_IDLE;
      end
    endcase
  end

  always_comb begin
    full_d      = (full_q & ~free_clr) | (set_full ? (2'b01 << wr_bank_q) : 2'b00);
    rd_bank_d   = rd_last ? ~rd_bank_q : rd_bank_q;
    rd_cnt_d    = rd_load ? rd_cnt_q + 1'b1 : rd_cnt_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    if (rd_load) begin
      out_valid_d = 1'b1;
      out_sop_d   = (rd_cnt_q == '0);
      out_eop_d   = (rd_cnt_q == LAST);
      out_lo_d    = rd_lo_w[rd_bank_q];
      out_hi_d    = rd_hi_w[rd_bank_q];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WR_IDLE;
      cnt_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      ovf_q       <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      ovf_q       <= ovf_d;
      sync_q      <= sync_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_i_real = out_lo_q[2*DW-1:DW];
  assign out_i_imag = out_lo_q[DW-1:0];
  assign out_j_real = out_hi_q[2*DW-1:DW];
  assign out_j_imag = out_hi_q[DW-1:0];
  assign overflow   = ovf_q;
  assign sync_err   = sync_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: a natural-order frame model feeds a queue of
// expected output pairs, plus directed sequences for stalls, drops and reset.
module tb_fft_bitrev_reorder;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0, in_sop = 1'b0;
  logic signed [15:0] in_i_real = '0, in_i_imag = '0, in_j_real = '0, in_j_imag = '0;
  logic              out_ready = 1'b1;
  logic              out_valid, out_sop, out_eop, overflow, sync_err;
  logic signed [15:0] out_i_real, out_i_imag, out_j_real, out_j_imag;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.DW(16), .LOG2N(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sop(in_sop),
    .in_i_real(in_i_real), .in_i_imag(in_i_imag),
    .in_j_real(in_j_real), .in_j_imag(in_j_imag),
    .out_ready(out_ready), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_i_real(out_i_real), .out_i_imag(out_i_imag),
    .out_j_real(out_j_real), .out_j_imag(out_j_imag),
    .overflow(overflow), .sync_err(sync_err)
  );

  typedef struct {
    logic [15:0] ir, ii, jr, ji;
    logic        sop, eop;
  } pair_t;

  typedef struct {
    int slot_lo, slot_hi;
    int exp_lo, exp_hi;
    bit exp_sop, exp_eop;
  } vec_t;

  pair_t exp_q[$];
  int    checks = 0, failures = 0;
  int    n_xfer = 0, run_len = 0, run_max = 0;
  bit    mon_en = 0, prev_stall = 0, rand_ready = 0, par = 0;
  logic [66:0] held;
  logic signed [15:0] fr_re[8], fr_im[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int tb_bitrev(input int i);
    return ((i % 2) * 4) + (((i / 2) % 2) * 2) + ((i / 4) % 2);
  endfunction

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (prev_stall)
        chk("hold_stable", {out_valid, out_sop, out_eop, out_i_real, out_i_imag, out_j_real, out_j_imag}, held);
      prev_stall = out_valid && !out_ready;
      held = {out_valid, out_sop, out_eop, out_i_real, out_i_imag, out_j_real, out_j_imag};
      if (out_valid && out_ready) begin
        pair_t e;
        n_xfer++;
        run_len++;
        if (run_len > run_max) run_max = run_len;
        $display("txn %0d: i=(%0d,%0d) j=(%0d,%0d) sop=%0b eop=%0b", n_xfer,
                 out_i_real, out_i_imag, out_j_real, out_j_imag, out_sop, out_eop);
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pair_data", {out_i_real, out_i_imag, out_j_real, out_j_imag, out_sop, out_eop},
              {e.ir, e.ii, e.jr, e.ji, e.sop, e.eop});
        end
      end else begin
        run_len = 0;
      end
    end else begin
      prev_stall = 0;
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) begin
      par = !par;
      out_ready = par || ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic put(input logic [15:0] a, b, c, d, input logic sop);
    in_valid = 1'b1; in_sop = sop;
    in_i_real = a; in_i_imag = b; in_j_real = c; in_j_imag = d;
    tick();
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int k = 0; k < 4; k++) begin
      int lo, hi;
      lo = tb_bitrev(2 * k);
      hi = tb_bitrev(2 * k + 1);
      put(fr_re[lo], fr_im[lo], fr_re[hi], fr_im[hi], k == 0);
      if (gap_max > 0 && k < 3) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic expect_frame();
    for (int m = 0; m < 4; m++) begin
      pair_t p;
      p.ir = fr_re[2*m]; p.ii = fr_im[2*m];
      p.jr = fr_re[2*m+1]; p.ji = fr_im[2*m+1];
      p.sop = (m == 0); p.eop = (m == 3);
      exp_q.push_back(p);
    end
  endtask

  task automatic set_frame(input int re_off, input int re_mul, input int im_off);
    for (int b = 0; b < 8; b++) begin
      fr_re[b] = 16'(re_mul * b + re_off);
      fr_im[b] = 16'(-b - im_off);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, out_valid, 1);
  endtask

  vec_t tbl[4];

  initial begin
    int x0;
    tbl[0] = '{0, 4, 0, 1, 1'b1, 1'b0};
    tbl[1] = '{2, 6, 2, 3, 1'b0, 1'b0};
    tbl[2] = '{1, 5, 4, 5, 1'b0, 1'b0};
    tbl[3] = '{3, 7, 6, 7, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {out_valid, out_sop, out_eop, out_i_real, out_i_imag,
                          out_j_real, out_j_imag, overflow, sync_err}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1;
    repeat (2) tick();

    // 1: table frame, value = bin
    for (int m = 0; m < 4; m++) begin
      pair_t p;
      p.ir = 16'(tbl[m].exp_lo); p.ii = 16'(-tbl[m].exp_lo);
      p.jr = 16'(tbl[m].exp_hi); p.ji = 16'(-tbl[m].exp_hi);
      p.sop = tbl[m].exp_sop; p.eop = tbl[m].exp_eop;
      exp_q.push_back(p);
    end
    for (int k = 0; k < 4; k++)
      put(16'(tbl[k].slot_lo), 16'(-tbl[k].slot_lo), 16'(tbl[k].slot_hi), 16'(-tbl[k].slot_hi), k == 0);
    @(negedge clk);
    chk("t1_latency_not_yet", out_valid, 0);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      chk("t1_table_pair", {out_valid, out_sop, out_eop, out_i_real, out_i_imag, out_j_real, out_j_imag},
          {1'b1, tbl[m].exp_sop, tbl[m].exp_eop, 16'(tbl[m].exp_lo), 16'(-tbl[m].exp_lo),
           16'(tbl[m].exp_hi), 16'(-tbl[m].exp_hi)});
    end
    wait_drain("t1_drain");

    // 2: back-to-back frames
    run_max = 0;
    set_frame(0, 1, 0);  expect_frame(); send_frame(0);
    set_frame(16, 1, 0); expect_frame(); send_frame(0);
    wait_drain("t2_drain");
    chk("t2_no_bubble", run_max >= 8, 1);
    chk("t2_overflow", overflow, 0);

    // randomized frames against the model, random back-pressure
    rand_ready = 1;
    for (int f = 0; f < 12; f++) begin
      for (int b = 0; b < 8; b++) begin
        fr_re[b] = 16'($urandom);
        fr_im[b] = 16'($urandom);
      end
      expect_frame();
      send_frame(2);
      repeat ($urandom_range(8, 12)) tick();
    end
    wait_drain("rand_drain");
    rand_ready = 0;
    out_ready = 1'b1;
    chk("rand_overflow", overflow, 0);
    chk("rand_sync_err", sync_err, 0);

    // 3: three frames while stalled; third is dropped
    out_ready = 1'b0;
    x0 = n_xfer;
    set_frame(32, 1, 0); expect_frame(); send_frame(0);
    set_frame(48, 1, 0); expect_frame(); send_frame(0);
    set_frame(64, 1, 0); send_frame(0);
    @(negedge clk);
    chk("t3_overflow", overflow, 1);
    chk("t3_no_xfer_stalled", n_xfer - x0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t3_drain");
    repeat (4) tick();
    chk("t3_pair_count", n_xfer - x0, 8);

    // 4: sop arriving at slot2 restarts the frame
    chk("t4_sync_before", sync_err, 0);
    put(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    put(16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b0);
    set_frame(200, 2, 3); expect_frame(); send_frame(0);
    @(negedge clk);
    chk("t4_sync_err", sync_err, 1);
    wait_drain("t4_drain");

    // 5: stall with pair (2,3) on the output
    out_ready = 1'b0;
    set_frame(100, 3, 1); expect_frame(); send_frame(0);
    wait_valid("t5_valid");
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_hold_pair1", {out_valid, out_sop, out_eop, out_i_real, out_j_real},
          {1'b1, 1'b0, 1'b0, fr_re[2], fr_re[3]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t5_drain");

    // 6: reset in the middle of a drain
    set_frame(300, 1, 0); expect_frame(); send_frame(0);
    wait_valid("t6_valid");
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 0;
    exp_q.delete();
    #1;
    chk("t6_reset_immediate", {out_valid, out_sop, out_eop, out_i_real, out_i_imag,
                               out_j_real, out_j_imag, overflow, sync_err}, 0);
    repeat (3) @(negedge clk);
    chk("t6_reset_held", {out_valid, overflow, sync_err}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1;
    set_frame(400, 5, 2); expect_frame(); send_frame(0);
    wait_drain("t6_after_reset");
    chk("t6_flags", {overflow, sync_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
